// File: rtl/servo_pkg.sv
// Constants and types shared between the servo PWM driver and the servo pulse decoder.
// The duty scale (0..DUTY_MAX over one nominal period) must stay identical on both sides.
package servo_pkg;

    localparam int SERVO_PERIOD_NS = 20_000_000;
    localparam int SYS_FREQ_MHZ    = 25;

    localparam int                DUTY_W   = 10;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 10'd1023;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEASURE_HIGH
    } decoder_state_t;

    // Counter width for a modulus, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/pwm_input_sync.sv
// Brings the external PWM pin into the clk25mhz domain and produces level plus rise/fall strobes.
// With SERVO_DECODER_GLITCH_FILTER_EN defined, the level only changes after FILTER_LEN equal samples.
module pwm_input_sync
    import servo_pkg::*;
`ifdef SERVO_DECODER_GLITCH_FILTER_EN
#(
    parameter int FILTER_LEN = 4
)
`endif
(
    input  logic clk25mhz,
    input  logic reset,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_meta;
    logic sync_q;
    logic level_q;
    logic level_prev;

    // Synchronizer resets to 1 so a pin already high at reset release is never seen
    // as a rising edge; the decoder waits for a genuine low level first.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk25mhz or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
        end else begin
            sync_meta <= pwm_in;
            sync_q    <= sync_meta;
        end
    end

`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    localparam int FILT_W = clog2_min1(FILTER_LEN);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);

    logic [FILT_W-1:0] filt_cnt;

    // Counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk25mhz or posedge reset) begin
        if (reset) begin
            level_q  <= 1'b1;
            filt_cnt <= '0;
        end else if (sync_q == level_q) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            level_q  <= sync_q;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end
`else
    assign level_q = sync_q;
`endif

    always_ff @(posedge clk25mhz or posedge reset) begin
        if (reset) begin
            level_prev <= 1'b1;
        end else begin
            level_prev <= level_q;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_prev;
    assign fall  = ~level_q & level_prev;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures the high time of an incoming servo PWM signal as a 0..1023 duty code and flags signal loss.
// Optional glitch filter on the input: define SERVO_DECODER_GLITCH_FILTER_EN.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int PERIOD_WIDTH_NS = SERVO_PERIOD_NS,
    parameter int SYS_FREQ_MHZ    = servo_pkg::SYS_FREQ_MHZ,
    parameter int TIMEOUT_PERIODS = 2
`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    ,
    parameter int FILTER_LEN      = 4
`endif
) (
    input  logic              clk25mhz,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              duty_valid,
    output logic              signal_lost
);

    localparam int PERIOD_CYCLES  = PERIOD_WIDTH_NS / 1000 * SYS_FREQ_MHZ;
    localparam int TICK_CYCLES    = PERIOD_CYCLES / (int'(DUTY_MAX) + 1);
    localparam int TIMEOUT_CYCLES = TIMEOUT_PERIODS * PERIOD_CYCLES;

    localparam int PRESC_W   = clog2_min1(TICK_CYCLES);
    localparam int TIMEOUT_W = clog2_min1(TIMEOUT_CYCLES);

    localparam logic [PRESC_W-1:0]   PRESC_LAST   = PRESC_W'(TICK_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic level;
    logic rise;
    logic fall;

    decoder_state_t       state;
    logic [PRESC_W-1:0]   presc;
    logic [DUTY_W-1:0]    high_cnt;
    logic [TIMEOUT_W-1:0] timeout_cnt;

    logic              tick_wrap;
    logic [DUTY_W-1:0] high_next;
    logic              timeout_hit;

    pwm_input_sync
`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    #(
        .FILTER_LEN (FILTER_LEN)
    )
`endif
    u_input_sync (
        .clk25mhz (clk25mhz),
        .reset    (reset),
        .pwm_in   (pwm_in),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    // The rise cycle is itself a high cycle, so the fall cycle folds in the last prescaler
    // step; the reported code is then exactly floor(high_cycles / TICK_CYCLES).
    assign tick_wrap   = (presc == PRESC_LAST);
    assign high_next   = (tick_wrap && (high_cnt != DUTY_MAX)) ? high_cnt + 1'b1 : high_cnt;
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk25mhz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            high_cnt    <= '0;
            timeout_cnt <= '0;
            duty_cycle  <= '0;
            duty_valid  <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            duty_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!level) begin
                        state       <= WAIT_RISE;
                        timeout_cnt <= '0;
                    end
                end

                WAIT_RISE: begin
                    if (rise) begin
                        state       <= MEASURE_HIGH;
                        presc       <= '0;
                        high_cnt    <= '0;
                        timeout_cnt <= '0;
                    end else if (timeout_hit) begin
                        state       <= IDLE;
                        signal_lost <= 1'b1;
                        duty_cycle  <= '0;
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end

                MEASURE_HIGH: begin
                    // A falling edge takes priority over a coincident timeout.
                    if (fall) begin
                        state       <= WAIT_RISE;
                        duty_cycle  <= high_next;
                        duty_valid  <= 1'b1;
                        signal_lost <= 1'b0;
                        timeout_cnt <= timeout_hit ? '0 : timeout_cnt + 1'b1;
                    end else if (timeout_hit) begin
                        state       <= IDLE;
                        signal_lost <= 1'b1;
                        duty_cycle  <= '0;
                        timeout_cnt <= '0;
                    end else begin
                        presc       <= tick_wrap ? '0 : presc + 1'b1;
                        high_cnt    <= high_next;
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench for servo_pulse_decoder on a shortened period (4000 cycles, tick 3, timeout 8000).
// Expected duty codes come from floor(high_cycles / tick) saturated at 1023.
module tb_servo_pulse_decoder;

    localparam int PERIOD_NS  = 160_000;
    localparam int FREQ_MHZ   = 25;
    localparam int TO_PERIODS = 2;
    localparam int FILT_LEN   = 4;

    localparam int PERIOD_CYC = PERIOD_NS / 1000 * FREQ_MHZ;
    localparam int TICK       = PERIOD_CYC / 1024;
    localparam int TIMEOUT    = TO_PERIODS * PERIOD_CYC;
`ifdef SERVO_DECODER_GLITCH_FILTER_EN
    localparam int LAT = 3 + FILT_LEN;
`else
    localparam int LAT = 3;
`endif

    logic       clk25mhz = 1'b0;
    logic       reset;
    logic       pwm_in;
    logic [9:0] duty_cycle;
    logic       duty_valid;
    logic       signal_lost;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_rise = 0;
    int got[$];
    int exp_q[$];
    logic valid_prev = 1'b0;
    logic lost_prev  = 1'b1;
    logic lost_before_valid = 1'b0;

    servo_pulse_decoder #(
        .PERIOD_WIDTH_NS (PERIOD_NS),
        .SYS_FREQ_MHZ    (FREQ_MHZ),
        .TIMEOUT_PERIODS (TO_PERIODS)
    ) dut (
        .clk25mhz    (clk25mhz),
        .reset       (reset),
        .pwm_in      (pwm_in),
        .duty_cycle  (duty_cycle),
        .duty_valid  (duty_valid),
        .signal_lost (signal_lost)
    );

    always #20 clk25mhz = ~clk25mhz;

    always @(posedge clk25mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Report monitor: collects every duty strobe and checks its shape.
    always @(negedge clk25mhz) begin
        if (duty_valid) begin
            got.push_back(int'(duty_cycle));
            lost_before_valid = lost_prev;
            check("valid_single_cycle", 32'(valid_prev), 0);
            check("lost_clears_with_valid", 32'(signal_lost), 0);
        end
        valid_prev = duty_valid;
        lost_prev  = signal_lost;
    end

    function automatic int model_duty(input int high_cycles);
        int code;
        code = high_cycles / TICK;
        return (code > 1023) ? 1023 : code;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk25mhz);
    endtask

    task automatic pulse(input int high, input int low);
        pwm_in    = 1'b1;
        last_rise = cyc;
        wait_cycles(high);
        pwm_in = 1'b0;
        wait_cycles(low);
    endtask

    task automatic expect_pulse(input int high, input int low);
        exp_q.push_back(model_duty(high));
        pulse(high, low);
    endtask

    task automatic compare_reports(input string tag);
        wait_cycles(LAT + 4);
        check({tag, "_count"}, got.size(), exp_q.size());
        while (got.size() > 0 && exp_q.size() > 0)
            check({tag, "_duty"}, got.pop_front(), exp_q.pop_front());
        got.delete();
        exp_q.delete();
    endtask

    task automatic wait_lost(input string tag);
        int n;
        n = 0;
        while (!signal_lost && n < 2 * TIMEOUT) begin
            @(negedge clk25mhz);
            n++;
        end
        check({tag, "_delay"}, cyc - last_rise, TIMEOUT + LAT);
        check({tag, "_duty_zero"}, 32'(duty_cycle), 0);
        check({tag, "_no_report"}, got.size(), 0);
    endtask

    initial begin
        int widths[4];
        reset  = 1'b1;
        pwm_in = 1'b0;
        wait_cycles(3);
        check("reset_duty", 32'(duty_cycle), 0);
        check("reset_valid", 32'(duty_valid), 0);
        check("reset_lost", 32'(signal_lost), 1);
        reset = 1'b0;

        // Low quarter period, then a 7.5% pulse.
        wait_cycles(PERIOD_CYC / 4);
        check("lost_before_first", 32'(signal_lost), 1);
        expect_pulse(300, 200);
        compare_reports("first_pulse");
        check("first_lost_transition", 32'(lost_before_valid), 1);
        check("lost_after_first", 32'(signal_lost), 0);

        // Periodic frames: 5% then 10% duty.
        expect_pulse(200, PERIOD_CYC - 200);
        expect_pulse(400, PERIOD_CYC - 400);
        compare_reports("frames_5_10");

        // Random frames, widths spanning the whole period including saturation.
        for (int i = 0; i < 5; i++) begin
            int h;
            h = int'($urandom_range(PERIOD_CYC - 8, FILT_LEN));
            expect_pulse(h, PERIOD_CYC - h);
        end
        compare_reports("random_frames");

        // Tick and saturation boundaries.
        widths = '{5, 3068, 3069, 3800};
        foreach (widths[i]) expect_pulse(widths[i], 300);
        compare_reports("boundaries");

        // Stuck low after a valid pulse.
        expect_pulse(300, 20);
        compare_reports("pre_stuck_low");
        check("lost_low_before", 32'(signal_lost), 0);
        wait_lost("stuck_low");

        // Stuck high after a valid pulse.
        wait_cycles(50);
        expect_pulse(300, 200);
        compare_reports("pre_stuck_high");
        pwm_in    = 1'b1;
        last_rise = cyc;
        wait_lost("stuck_high");
        pwm_in = 1'b0;
        wait_cycles(100);
        check("stuck_high_release_no_report", got.size(), 0);
        check("stuck_high_release_lost", 32'(signal_lost), 1);

        // Pin high at reset release: partial pulse discarded.
        pwm_in = 1'b1;
        reset  = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(140);
        pwm_in = 1'b0;
        wait_cycles(500);
        check("partial_no_report", got.size(), 0);
        expect_pulse(300, 200);
        compare_reports("after_partial");

        // Reset in the middle of a pulse.
        pwm_in = 1'b1;
        wait_cycles(20);
        reset = 1'b1;
        #1;
        check("midreset_duty", 32'(duty_cycle), 0);
        check("midreset_valid", 32'(duty_valid), 0);
        check("midreset_lost", 32'(signal_lost), 1);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(280);
        pwm_in = 1'b0;
        wait_cycles(300);
        check("midreset_no_report", got.size(), 0);
        expect_pulse(300, 200);
        compare_reports("after_midreset");

        // Two-cycle low glitch one third of the way into a 300-cycle pulse.
`ifdef SERVO_DECODER_GLITCH_FILTER_EN
        exp_q.push_back(model_duty(300));
`else
        exp_q.push_back(model_duty(100));
        exp_q.push_back(model_duty(198));
`endif
        pwm_in = 1'b1;
        wait_cycles(100);
        pwm_in = 1'b0;
        wait_cycles(2);
        pwm_in = 1'b1;
        wait_cycles(198);
        pwm_in = 1'b0;
        wait_cycles(200);
        compare_reports("glitch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
